// File: rtl/xdelay_ctrl_pkg.sv
// Shared channel definitions for the summing delay line and its controller.
// Holds the controller state encoding, the delay line pipe depth and the DMAX helper.
package xdelay_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } xdelay_state_e;

  localparam int unsigned XDELAY_PIPE = 2;

  // Largest delay that still keeps the read pointer behind the write wrap.
  function automatic int unsigned xdelay_dmax(input int unsigned dbits);
    return (32'd1 << dbits) - 32'd2;
  endfunction

endpackage

// File: rtl/xdelay_ctrl.sv
// Delay configuration and output-valid sequencing for the circular-buffer summing delay line.
// Clamps register writes to the safe range and masks the line output until it is refilled.
module xdelay_ctrl
  import xdelay_ctrl_pkg::*;
#(
  parameter int unsigned DBITS = 5,
  parameter int unsigned DMIN  = 1,
  parameter int unsigned DMAX  = xdelay_dmax(DBITS),
  parameter int unsigned PIPE  = XDELAY_PIPE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_wr,
  input  logic [DBITS-1:0] cfg_delay,
  input  logic             cfg_clr,
  output logic             cfg_ack,
  output logic [DBITS-1:0] xdelay,
  output logic             dout_valid,
  output logic             busy,
  output logic             clamp_err,
  output logic [7:0]       chg_cnt
);

  localparam int unsigned      CW     = DBITS + 1;
  localparam logic [DBITS-1:0] DMIN_V = DBITS'(DMIN);
  localparam logic [DBITS-1:0] DMAX_V = DBITS'(DMAX);
  localparam logic [CW-1:0]    PIPE_V = CW'(PIPE);

  xdelay_state_e    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DBITS-1:0] xdelay_q, xdelay_d;
  logic             cfg_ack_q, cfg_ack_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             clamp_err_q, clamp_err_d;
  logic [7:0]       chg_cnt_q, chg_cnt_d;
  logic [DBITS-1:0] eff_c;
  logic             clamped_c;

  // Clamp the requested delay into the range the line can serve.
  always_comb begin
    eff_c = cfg_delay;
    if (cfg_delay < DMIN_V) begin
      eff_c = DMIN_V;
    end else if (cfg_delay > DMAX_V) begin
      eff_c = DMAX_V;
    end
    clamped_c = (eff_c != cfg_delay);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xdelay_d    = xdelay_q;
    cfg_ack_d   = 1'b0;
    clamp_err_d = clamp_err_q;
    chg_cnt_d   = chg_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_FILL;
          cnt_d   = CW'(xdelay_q) + PIPE_V;
        end
      end
      ST_FILL: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= CW'(1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write always takes effect and restarts the fill, whatever the state.
    if (cfg_wr) begin
      xdelay_d  = eff_c;
      cfg_ack_d = 1'b1;
      if (chg_cnt_q != 8'hFF) begin
        chg_cnt_d = chg_cnt_q + 8'd1;
      end
      if (enable) begin
        state_d = ST_FILL;
        cnt_d   = CW'(eff_c) + PIPE_V;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Setting the sticky flag takes priority over a same-cycle clear.
    if (cfg_wr && clamped_c) begin
      clamp_err_d = 1'b1;
    end else if (cfg_clr) begin
      clamp_err_d = 1'b0;
    end

    busy_d       = (state_d == ST_FILL);
    dout_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      xdelay_q     <= DMIN_V;
      cfg_ack_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      clamp_err_q  <= 1'b0;
      chg_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      xdelay_q     <= xdelay_d;
      cfg_ack_q    <= cfg_ack_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      clamp_err_q  <= clamp_err_d;
      chg_cnt_q    <= chg_cnt_d;
    end
  end

  assign cfg_ack    = cfg_ack_q;
  assign xdelay     = xdelay_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign clamp_err  = clamp_err_q;
  assign chg_cnt    = chg_cnt_q;

endmodule

// File: tb/tb_xdelay_ctrl.sv
// Scoreboard bench for xdelay_ctrl: writes queue their expected ack snapshot and
// valid-rise cycle; a monitor pops and compares whenever the DUT presents them.
module tb_xdelay_ctrl;

  localparam int unsigned DBITS = 5;

  typedef struct {
    logic [4:0] xd;
    logic [7:0] cnt;
    logic       clamp;
  } ack_t;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             cfg_wr;
  logic [DBITS-1:0] cfg_delay;
  logic             cfg_clr;
  logic             cfg_ack;
  logic [DBITS-1:0] xdelay;
  logic             dout_valid;
  logic             busy;
  logic             clamp_err;
  logic [7:0]       chg_cnt;

  xdelay_ctrl #(.DBITS(DBITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_wr     (cfg_wr),
    .cfg_delay  (cfg_delay),
    .cfg_clr    (cfg_clr),
    .cfg_ack    (cfg_ack),
    .xdelay     (xdelay),
    .dout_valid (dout_valid),
    .busy       (busy),
    .clamp_err  (clamp_err),
    .chg_cnt    (chg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  ack_t ack_q[$];
  int   rise_q[$];

  logic [4:0] m_xd    = 5'd1;
  logic [7:0] m_cnt   = 8'd0;
  logic       m_clamp = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one write; the expectation is queued before the strobe goes out.
  task automatic do_write(input logic [4:0] d, input bit clr, input bit expect_rise);
    logic [4:0] eff;
    ack_t a;
    eff = (d < 5'd1) ? 5'd1 : ((d > 5'd30) ? 5'd30 : d);
    m_xd = eff;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    if (eff != d) m_clamp = 1'b1;
    else if (clr) m_clamp = 1'b0;
    a.xd = m_xd;
    a.cnt = m_cnt;
    a.clamp = m_clamp;
    ack_q.push_back(a);
    if (expect_rise) rise_q.push_back(cyc + 1 + int'(eff) + 2);
    cfg_wr = 1'b1;
    cfg_delay = d;
    cfg_clr = clr;
    tick();
    cfg_wr = 1'b0;
    cfg_clr = 1'b0;
  endtask

  task automatic do_clr();
    m_clamp = 1'b0;
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
    chk("clamp_err_after_clr", int'(clamp_err), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    cfg_wr = 1'b0;
    cfg_delay = '0;
    cfg_clr = 1'b0;

    fork
      begin : monitor
        logic prev;
        ack_t a;
        int   e;
        prev = 1'b0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            prev = 1'b0;
          end else begin
            if (cfg_ack) begin
              if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected: got ack=1 expected no ack (cycle %0d)", cyc);
              end else begin
                a = ack_q.pop_front();
                chk("ack_xdelay", int'(xdelay), int'(a.xd));
                chk("ack_chg_cnt", int'(chg_cnt), int'(a.cnt));
                chk("ack_clamp_err", int'(clamp_err), int'(a.clamp));
              end
            end
            if (dout_valid && !prev) begin
              if (rise_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid_rise_unexpected: got rise at cycle %0d expected none", cyc);
              end else begin
                e = rise_q.pop_front();
                chk("valid_rise_cycle", cyc, e);
              end
            end
            prev = dout_valid;
          end
        end
      end

      begin : stimulus
        // Reset values
        wait_n(2);
        chk("rst_xdelay", int'(xdelay), 1);
        chk("rst_cfg_ack", int'(cfg_ack), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clamp_err", int'(clamp_err), 0);
        chk("rst_chg_cnt", int'(chg_cnt), 0);
        rst_n = 1'b1;
        wait_n(2);

        // Enable with default delay 1: three invalid clocks
        rise_q.push_back(cyc + 1 + 3);
        enable = 1'b1;
        tick();
        chk("fill_busy", int'(busy), 1);
        chk("fill_dout_valid", int'(dout_valid), 0);
        wait_n(6);

        // Delay 10 from RUN: twelve invalid clocks
        do_write(5'd10, 1'b0, 1'b1);
        wait_n(15);

        // Clamping writes at both ends, then clear
        do_write(5'd0, 1'b0, 1'b1);
        wait_n(6);
        do_write(5'd31, 1'b0, 1'b1);
        do_clr();
        wait_n(34);
        do_write(5'd31, 1'b1, 1'b1);
        chk("clr_vs_clamp_set_wins", int'(clamp_err), 1);
        wait_n(34);
        do_clr();

        // Restart a long fill with a short delay
        do_write(5'd20, 1'b0, 1'b0);
        wait_n(4);
        do_write(5'd4, 1'b0, 1'b1);
        wait_n(9);

        // One-clock enable drop in RUN, then refill
        chk("run_dout_valid", int'(dout_valid), 1);
        enable = 1'b0;
        tick();
        chk("drop_dout_valid", int'(dout_valid), 0);
        chk("drop_busy", int'(busy), 0);
        rise_q.push_back(cyc + 1 + 4 + 2);
        enable = 1'b1;
        tick();
        chk("refill_busy", int'(busy), 1);
        wait_n(8);

        // Reset mid-FILL with a write pending: no ack, reset values
        do_write(5'd10, 1'b0, 1'b0);
        wait_n(3);
        chk("midfill_busy", int'(busy), 1);
        enable = 1'b0;
        cfg_wr = 1'b1;
        cfg_delay = 5'd9;
        rst_n = 1'b0;
        tick();
        cfg_wr = 1'b0;
        m_xd = 5'd1;
        m_cnt = 8'd0;
        m_clamp = 1'b0;
        chk("abort_cfg_ack", int'(cfg_ack), 0);
        chk("abort_xdelay", int'(xdelay), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_dout_valid", int'(dout_valid), 0);
        chk("abort_chg_cnt", int'(chg_cnt), 0);
        chk("abort_clamp_err", int'(clamp_err), 0);
        rst_n = 1'b1;
        wait_n(2);

        // 300 back-to-back writes with enable low: saturation, IDLE held
        for (int i = 0; i < 300; i++) begin
          do_write(5'(i), 1'b0, 1'b0);
        end
        tick();
        chk("sat_chg_cnt", int'(chg_cnt), 255);
        chk("idle_xdelay", int'(xdelay), 11);
        chk("idle_busy", int'(busy), 0);
        chk("idle_dout_valid", int'(dout_valid), 0);

        // Enable, then rewrite the same value: still acked and refilled
        rise_q.push_back(cyc + 1 + 11 + 2);
        enable = 1'b1;
        wait_n(15);
        do_write(5'd11, 1'b0, 1'b1);
        chk("same_val_restart_busy", int'(busy), 1);
        wait_n(16);

        chk("ack_queue_drained", ack_q.size(), 0);
        chk("rise_queue_drained", rise_q.size(), 0);
      end
    join_any
    disable fork;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
